// File: rtl/uart_pkg.sv
// Shared UART constants and the scheduler state type.
// Contents:
//   DEF_FRAME_BITS - bits per UART frame (start + 8 data + stop)
//   DEF_BAUD_DIV   - clk cycles per UART bit (100 MHz / 9600 baud)
//   state_t        - frame scheduler states: IDLE (line free), WAIT (frame in flight)
package uart_pkg;

   localparam int DEF_FRAME_BITS = 10;
   localparam int DEF_BAUD_DIV   = 10417;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bundle between the byte requesters and the UART transmit scheduler.
// Signals:
//   enable      - requester side: allows new grants when high
//   req         - requester side: per-requester request level, held until ack
//   req_data    - requester side: byte for requester i on bits [8i+7:8i]
//   ack         - scheduler side: one-hot, one-cycle acceptance pulse
//   tx_transmit - scheduler side: one-cycle start pulse for the Transmitter
//   tx_data     - scheduler side: byte held on the Transmitter input for the frame
//   busy        - scheduler side: high while a frame owns the line
//   grant_id    - scheduler side: index of the last granted requester
// Modports: master = requester/user side, slave = scheduler.
interface uart_tx_scheduler_if #(
   parameter int NUM_REQ = 4
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic                   enable;
   logic [NUM_REQ-1:0]     req;
   logic [8*NUM_REQ-1:0]   req_data;
   logic [NUM_REQ-1:0]     ack;
   logic                   tx_transmit;
   logic [7:0]             tx_data;
   logic                   busy;
   logic [IDX_W-1:0]       grant_id;

   modport master (
      output enable, req, req_data,
      input  ack, tx_transmit, tx_data, busy, grant_id
   );

   modport slave (
      input  enable, req, req_data,
      output ack, tx_transmit, tx_data, busy, grant_id
   );

endinterface

// File: rtl/uart_tx_scheduler_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// The search starts one above the last winner and wraps modulo NUM_REQ,
// so the most recent winner has the lowest priority.
// Ports:
//   req_i    - request vector
//   last_i   - index of the previous winner
//   valid_o  - at least one request is set
//   winner_o - index of the chosen requester (meaningful only when valid_o)
module rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic               valid_o,
   output logic [IDX_W-1:0]   winner_o
);

   localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

   logic [IDX_W:0]     start;    // first index searched, in 0..NUM_REQ
   logic [NUM_REQ-1:0] req_rot;  // req_rot[k] = req_i[(start + k) mod NUM_REQ]
   logic [IDX_W-1:0]   offset;   // distance from start to the first set request
   logic [IDX_W:0]     sum;

   always_comb begin
      // NOTE: every variable gets a value before any conditional update, so no latch is inferred.
      offset  = '0;
      start   = {1'b0, last_i} + (IDX_W+1)'(1);
      // Doubling the vector turns the wrap-around into a plain right shift.
      req_rot = NUM_REQ'({req_i, req_i} >> start);
      // Walk downward so the smallest offset is the one left standing.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_rot[k[IDX_W-1:0]]) begin
            offset = k[IDX_W-1:0];
         end
      end
      // start + offset is at most 2*NUM_REQ-1, so one subtraction folds it back.
      sum = start + {1'b0, offset};
      if (sum >= NUM_REQ_W) begin
         sum = sum - NUM_REQ_W;
      end
      valid_o  = |req_i;
      winner_o = sum[IDX_W-1:0];
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART Transmitter between NUM_REQ byte
// requesters with round-robin arbitration. The Transmitter has no busy
// output, so the frame length is timed here and no new grant is issued
// until the line is free again.
// Ports:
//   clk   - system clock, all logic on the rising edge
//   reset - asynchronous, active-high reset (also resets the Transmitter)
//   bus   - uart_tx_scheduler_if.slave: enable/req/req_data in,
//           ack/tx_transmit/tx_data/busy/grant_id out
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int BAUD_DIV   = DEF_BAUD_DIV,
   parameter int FRAME_BITS = DEF_FRAME_BITS
) (
   input  logic               clk,
   input  logic               reset,
   uart_tx_scheduler_if.slave bus
);

   localparam int FRAME_CYCLES = BAUD_DIV * FRAME_BITS;
   localparam int IDX_W        = $clog2(NUM_REQ);
   localparam int CNT_W        = $clog2(FRAME_CYCLES);

   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(FRAME_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_RESET = IDX_W'(NUM_REQ - 1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 tx_transmit_q, tx_transmit_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 busy_q, busy_d;
   logic [IDX_W-1:0]     grant_id_q, grant_id_d;

   logic                 pick_valid;
   logic [IDX_W-1:0]     pick_idx;
   logic [7:0]           req_bytes [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
      assign req_bytes[g] = bus.req_data[8*g +: 8];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_i    (bus.req),
      .last_i   (grant_id_q),
      .valid_o  (pick_valid),
      .winner_o (pick_idx)
   );

   // Next-state and output logic. tx_transmit and ack default to 0, so they
   // only ever last the single cycle after a grant.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      tx_data_d     = tx_data_q;
      tx_transmit_d = 1'b0;
      ack_d         = '0;
      busy_d        = busy_q;
      grant_id_d    = grant_id_q;

      case (state_q)
         IDLE: begin
            if (bus.enable && pick_valid) begin
               state_d       = WAIT;
               cnt_d         = CNT_LOAD;
               tx_data_d     = req_bytes[pick_idx];
               tx_transmit_d = 1'b1;
               ack_d         = NUM_REQ'(1) << pick_idx;
               grant_id_d    = pick_idx;
               busy_d        = 1'b1;
            end
         end
         WAIT: begin
            // Requests are ignored here; enable is ignored too, so a frame
            // in flight always runs to completion.
            if (cnt_q == '0) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         tx_data_q     <= '0;
         tx_transmit_q <= 1'b0;
         ack_q         <= '0;
         busy_q        <= 1'b0;
         grant_id_q    <= IDX_RESET;  // requester 0 has first priority
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tx_data_q     <= tx_data_d;
         tx_transmit_q <= tx_transmit_d;
         ack_q         <= ack_d;
         busy_q        <= busy_d;
         grant_id_q    <= grant_id_d;
      end
   end

   assign bus.ack         = ack_q;
   assign bus.tx_transmit = tx_transmit_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.busy        = busy_q;
   assign bus.grant_id    = grant_id_q;

endmodule
